instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the core's immediate generator: packs a 64-bit immediate plus register/opcode fields into a
//  32-bit RV64 instruction for I/S/B/J/U formats, and range/alignment-checks the immediate.
//  Feeds the self-test instruction generator and the trap-stub writer; valid/ready in, valid/ready out,
//  encoded words buffered in a small FIFO.
// PARAMETERS
//  DEPTH  2   output FIFO entries; power of 2, >=2
//  CNT_W  16  width of saturating statistics counters
// PORTS
//  clk            in   1   core clock; all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  in_valid       in   1   request valid
//  in_ready       out  1   request accepted when in_valid&in_ready
//  in_fmt         in   3   000 I, 001 S, 010 B, 011 J, 100 U; 101-111 illegal
//  in_immediate   in   64  sign-extended immediate value (byte offset for B/J)
//  in_opcode      in   7   instr[6:0]
//  in_rd          in   5   instr[11:7] (I/J/U)
//  in_rs1         in   5   instr[19:15] (I/S/B)
//  in_rs2         in   5   instr[24:20] (S/B)
//  in_funct3      in   3   instr[14:12] (I/S/B)
//  out_valid      out  1   FIFO head valid
//  out_ready      in   1   consumer takes head when out_valid&out_ready
//  out_instr      out  32  encoded instruction
//  out_err        out  2   00 ok, 01 range, 10 misaligned, 11 illegal fmt
//  enc_count      out  CNT_W  accepted requests, saturating
//  err_count      out  CNT_W  accepted requests with out_err!=0, saturating
// BEHAVIOUR
//  Field packing (imm = in_immediate):
//   I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; U {imm[31:12],rd,op}
//  Checks:
//   I/S: range err unless imm[63:11] all equal
//   B: range unless imm[63:12] all equal; misaligned if imm[0]
//   J: range unless imm[63:20] all equal; misaligned if imm[0]
//   U: range unless imm[63:31] all equal; misaligned if imm[11:0]!=0
//   Priority illegal > misaligned > range. On error the word is still packed from truncated fields.
//   Illegal fmt: out_instr=32'h0.
//  Encoding is combinational at the FIFO write port. A request accepted in cycle N is visible at
//  out_* in cycle N+1 when the FIFO was empty. No combinational in->out path.
//  in_ready = !full. No write when full, even if a pop happens in the same cycle.
//  When not full, simultaneous push and pop are allowed and the count is unchanged.
//  out_instr/out_err hold the head entry. They are 0 when empty.
//  out_valid must stay high until popped, and head data must be stable while out_valid&!out_ready.
//  Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
//  enc_count increments on each accept. err_count increments on accept with err!=0.
//  Both hold at 2^CNT_W-1.
//  Reset, including mid-stream: FIFO flushed, out_valid=0, out_instr=0, out_err=0, counters=0.
//  in_ready=1 from the first cycle after reset deasserts.
// STRUCTURE
//  core_pkg gets:
//   imm_fmt_e (IMM_I..IMM_U, shared with the immediate generator's select)
//   enc_err_e
//   a pure function pack_imm(fmt, imm, fields) -> {instr, err}
//  Sub-module sync_fifo #(WIDTH=34, DEPTH): one-clock FIFO with synchronous active-high reset,
//  reusable elsewhere in the core.
//  Top level = pack_imm + sync_fifo + counters.
// TESTING
//  I, imm=64'hFFFF_FFFF_FFFF_FFFF, rs1=2, rd=1, f3=0, op=7'h13 -> 32'hFFF10093, err 00, one cycle later.
//  B, imm=-4, rs1=1, rs2=2, f3=1, op=7'h63 -> 32'hFE209EE3, err 00.
//  I imm=2048 -> err 01; J imm=5 -> err 10; U imm=64'h1234 -> err 10; fmt 3'b111 -> instr 0, err 11.
//   err_count=4, enc_count=4.
//  Backpressure, DEPTH=2, out_ready=0:
//   two accepts, then in_ready=0 with head stable
//   raise out_ready -> words drain in order, in_ready returns the cycle after the first pop
//  Round trip: 10k random legal (fmt, imm) -> feed out_instr to the immediate generator with the same
//   select -> output equals the original imm.
//  Reset asserted with 2 entries queued -> next cycle out_valid=0, counters=0, in_ready=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: immediate formats, encoder error codes and the pure
// immediate-packing function used by the instruction encoder.
package core_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ENC_OK       = 2'b00,
    ENC_RANGE    = 2'b01,
    ENC_MISALIGN = 2'b10,
    ENC_ILLEGAL  = 2'b11
  } enc_err_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
  } enc_fields_t;

  typedef struct packed {
    logic [31:0] instr;
    enc_err_e    err;
  } enc_word_t;

  localparam int ENC_WORD_W = $bits(enc_word_t);

  // Range checks ask whether the upper bits are a pure sign extension of the field.
  function automatic enc_word_t pack_imm(input logic [2:0] fmt, input logic [63:0] imm,
                                         input enc_fields_t f);
    enc_word_t w;
    logic      in_range;
    logic      misaligned;
    logic      illegal;
    w          = '0;
    in_range   = 1'b1;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (fmt)
      IMM_I: begin
        w.instr  = {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
        in_range = (&imm[63:11]) | ~(|imm[63:11]);
      end
      IMM_S: begin
        w.instr  = {imm[11:5], f.rs2, f.rs1, f.funct3, imm[4:0], f.opcode};
        in_range = (&imm[63:11]) | ~(|imm[63:11]);
      end
      IMM_B: begin
        w.instr    = {imm[12], imm[10:5], f.rs2, f.rs1, f.funct3, imm[4:1], imm[11], f.opcode};
        in_range   = (&imm[63:12]) | ~(|imm[63:12]);
        misaligned = imm[0];
      end
      IMM_J: begin
        w.instr    = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
        in_range   = (&imm[63:20]) | ~(|imm[63:20]);
        misaligned = imm[0];
      end
      IMM_U: begin
        w.instr    = {imm[31:12], f.rd, f.opcode};
        in_range   = (&imm[63:31]) | ~(|imm[63:31]);
        misaligned = |imm[11:0];
      end
      default: begin
        w.instr = '0;
        illegal = 1'b1;
      end
    endcase
    if (illegal)        w.err = ENC_ILLEGAL;
    else if (misaligned) w.err = ENC_MISALIGN;
    else if (!in_range)  w.err = ENC_RANGE;
    else                 w.err = ENC_OK;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// Read data is zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full FIFO refuses writes even if the head leaves in the same cycle.
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Packs an immediate plus register/opcode fields into a 32-bit RV64 word,
// checks the immediate, and queues {instr, err} for the consumer.
module instr_encoder
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [63:0]      in_immediate,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  enc_fields_t fields;
  enc_word_t   enc_word;
  enc_word_t   head;
  logic        full;
  logic        empty;
  logic        accept;

  // Handshakes: a beat transfers on a rising edge where valid&ready; valid never
  // waits on ready, and a producer holds valid and data stable until the transfer.
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;

  assign fields = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2, funct3: in_funct3};
  assign enc_word = pack_imm(in_fmt, in_immediate, fields);

  sync_fifo #(.WIDTH(ENC_WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (enc_word),
    .full    (full),
    .rd_en   (out_ready),
    .rd_data (head),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign out_instr = head.instr;
  assign out_err   = head.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (enc_count != '1) enc_count <= enc_count + CNT_W'(1);
      if (enc_word.err != ENC_OK && err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases, backpressure and reset,
// then randomized traffic against an arithmetic model and round-trip decoder.
module tb_instr_encoder;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_fmt = '0;
  logic [63:0]      in_immediate = '0;
  logic [6:0]       in_opcode = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [1:0]       out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int failures = 0;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_immediate(in_immediate), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [33:0] model_encode(input logic [2:0] f, input logic [63:0] imm,
      input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3);
    longint      s;
    logic [63:0] w, o, d, r1, r2, t;
    logic [1:0]  err;
    bit          in_range, mis, illegal;
    s = imm; o = {57'd0, op}; d = {59'd0, rd}; r1 = {59'd0, rs1}; r2 = {59'd0, rs2};
    t = {61'd0, f3};
    w = 0; in_range = 1; mis = 0; illegal = 0;
    case (f)
      3'd0: begin
        w = ((imm & 64'hfff) << 20) | (r1 << 15) | (t << 12) | (d << 7) | o;
        in_range = (s >= -2048) && (s <= 2047);
      end
      3'd1: begin
        w = (((imm >> 5) & 64'h7f) << 25) | (r2 << 20) | (r1 << 15) | (t << 12)
          | ((imm & 64'h1f) << 7) | o;
        in_range = (s >= -2048) && (s <= 2047);
      end
      3'd2: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 64'h3f) << 25) | (r2 << 20)
          | (r1 << 15) | (t << 12) | (((imm >> 1) & 64'hf) << 8) | (((imm >> 11) & 1) << 7) | o;
        in_range = (s >= -4096) && (s <= 4095);
        mis = (imm & 1) != 0;
      end
      3'd3: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 64'h3ff) << 21)
          | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 64'hff) << 12) | (d << 7) | o;
        in_range = (s >= -1048576) && (s <= 1048575);
        mis = (imm & 1) != 0;
      end
      3'd4: begin
        w = (imm & 64'hffff_f000) | (d << 7) | o;
        in_range = (s >= -64'sd2147483648) && (s <= 64'sd2147483647);
        mis = (imm & 64'hfff) != 0;
      end
      default: illegal = 1;
    endcase
    err = illegal ? 2'd3 : mis ? 2'd2 : !in_range ? 2'd1 : 2'd0;
    return {w[31:0], err};
  endfunction

  // Independent immediate generator: recovers the sign-extended immediate from a word.
  function automatic logic [63:0] rt_decode(input logic [2:0] f, input logic [31:0] wd);
    longint u, v;
    u = {32'd0, wd};
    v = 0;
    case (f)
      3'd0: begin v = u >> 20; if (v >= 2048) v -= 4096; end
      3'd1: begin v = ((u >> 25) << 5) | ((u >> 7) & 31); if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
          | (((u >> 8) & 15) << 1);
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin
        v = (((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
          | (((u >> 21) & 1023) << 1);
        if (v >= 1048576) v -= 2097152;
      end
      default: begin
        v = u & 64'hffff_f000;
        if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
      end
    endcase
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [66:0] info_q[$];
  int          m_enc = 0;
  int          m_err = 0;
  int          m_legal = 0;
  bit          model_live = 0;
  bit          m_acc, m_pop;
  logic [33:0] m_word;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      info_q.delete();
      m_enc = 0;
      m_err = 0;
      model_live = 1;
    end else if (model_live) begin
      m_acc  = in_valid && (exp_q.size() < DEPTH);
      m_pop  = out_ready && (exp_q.size() != 0);
      m_word = model_encode(in_fmt, in_immediate, in_opcode, in_rd, in_rs1, in_rs2, in_funct3);
      if (m_pop) begin
        void'(exp_q.pop_front());
        void'(info_q.pop_front());
      end
      if (m_acc) begin
        exp_q.push_back(m_word);
        info_q.push_back({in_fmt, in_immediate});
        if (m_enc < CNT_MAX) m_enc++;
        if (m_word[1:0] != 2'd0 && m_err < CNT_MAX) m_err++;
        if (m_word[1:0] == 2'd0) m_legal++;
      end
    end
  end

  logic [33:0] c_word;
  always @(negedge clk) begin
    if (model_live && !rst) begin
      c_word = (exp_q.size() != 0) ? exp_q[0] : 34'd0;
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < DEPTH});
      chk("out_instr", {32'd0, out_instr}, {32'd0, c_word[33:2]});
      chk("out_err", {62'd0, out_err}, {62'd0, c_word[1:0]});
      chk("enc_count", 64'(enc_count), 64'(m_enc));
      chk("err_count", 64'(err_count), 64'(m_err));
      if (exp_q.size() != 0 && c_word[1:0] == 2'd0)
        chk("round_trip", rt_decode(info_q[0][66:64], out_instr), info_q[0][63:0]);
    end
  end

  // ---------------- drivers ----------------
  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [63:0] imm, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3);
    int waited;
    waited = 0;
    in_fmt = f; in_immediate = imm; in_opcode = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [63:0] edges [12] = '{64'd2047, 64'd2048, -64'd2048, -64'd2049, 64'd4094, 64'd4096,
                              -64'd4096, -64'd4098, 64'd1048574, 64'd1048576,
                              64'h0000_0000_7fff_f000, 64'h0000_0000_8000_0000};

  task automatic drive_random();
    logic [31:0] r;
    r = $urandom();
    in_valid  = ($urandom_range(0, 9) < 7);
    out_ready = ($urandom_range(0, 3) != 0);
    in_opcode = 7'($urandom()); in_rd = 5'($urandom()); in_rs1 = 5'($urandom());
    in_rs2 = 5'($urandom()); in_funct3 = 3'($urandom());
    if ($urandom_range(0, 9) == 0) begin
      if ($urandom_range(0, 1) == 0) begin
        in_fmt = 3'($urandom_range(0, 7));
        in_immediate = {$urandom(), $urandom()};
      end else begin
        in_fmt = 3'($urandom_range(0, 4));
        in_immediate = edges[$urandom_range(0, 11)];
      end
    end else begin
      in_fmt = 3'($urandom_range(0, 4));
      case (in_fmt)
        3'd0, 3'd1: in_immediate = {{52{r[11]}}, r[11:0]};
        3'd2:       in_immediate = {{51{r[12]}}, r[12:1], 1'b0};
        3'd3:       in_immediate = {{43{r[20]}}, r[20:1], 1'b0};
        default:    in_immediate = {{32{r[31]}}, r[31:12], 12'h000};
      endcase
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_instr", {32'd0, out_instr}, 64'd0);
    chk("reset_enc_count", 64'(enc_count), 64'd0);

    out_ready = 1'b1;
    send(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0);
    chk("lit_i_instr", {32'd0, out_instr}, 64'hFFF10093);
    chk("lit_i_err", {62'd0, out_err}, 64'd0);
    chk("lit_i_valid", {63'd0, out_valid}, 64'd1);
    send(3'd2, -64'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1);
    chk("lit_b_instr", {32'd0, out_instr}, 64'hFE209EE3);
    chk("lit_b_err", {62'd0, out_err}, 64'd0);

    do_reset();
    send(3'd0, 64'd2048, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0);
    chk("lit_i_range", {62'd0, out_err}, 64'd1);
    send(3'd3, 64'd5, 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0);
    chk("lit_j_mis", {62'd0, out_err}, 64'd2);
    send(3'd4, 64'h1234, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
    chk("lit_u_mis", {62'd0, out_err}, 64'd2);
    send(3'd7, 64'd0, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1);
    chk("lit_ill_instr", {32'd0, out_instr}, 64'd0);
    chk("lit_ill_err", {62'd0, out_err}, 64'd3);
    chk("lit_enc_count", 64'(enc_count), 64'd4);
    chk("lit_err_count", 64'(err_count), 64'd4);

    // Backpressure: fill, hold, then drain in order.
    do_reset();
    out_ready = 1'b0;
    send(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0);
    send(3'd2, -64'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1);
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    in_fmt = 3'd7; in_immediate = 64'd0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("bp_head_stable", {32'd0, out_instr}, 64'hFFF10093);
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_second_head", {32'd0, out_instr}, 64'hFE209EE3);
    chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
    @(negedge clk); #1;
    in_valid = 1'b0;
    chk("bp_third_head", {32'd0, out_instr}, 64'd0);
    chk("bp_third_err", {62'd0, out_err}, 64'd3);
    @(negedge clk); #1;
    chk("bp_drained", {63'd0, out_valid}, 64'd0);

    // Reset with two entries queued.
    out_ready = 1'b0;
    send(3'd0, 64'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
    send(3'd0, 64'd2, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("midrst_enc_count", 64'(enc_count), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;

    m_legal = 0;
    cyc = 0;
    while (m_legal < 10000 && cyc < 60000) begin
      @(negedge clk); #1;
      drive_random();
      cyc++;
    end
    chk("random_budget", {63'd0, m_legal >= 10000}, 64'd1);

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("final_drained", {63'd0, out_valid}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
